// File: rtl/sci_bus_ctrl.sv
// sci_bus_ctrl: CPU bus register front end for the SCI UART; define SCI_RX_TIMEOUT_EN to build the RX idle timeout
module sci_bus_ctrl #(
   parameter logic [15:0] P_TIMEOUT = 16'd4000
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iRESET_SYNC,
   input  logic        iREQ_VALID,
   output logic        oREQ_BUSY,
   input  logic        iREQ_RW,
   input  logic [1:0]  iREQ_ADDR,
   input  logic [31:0] iREQ_DATA,
   output logic        oREQ_VALID,
   output logic [31:0] oREQ_DATA,
   output logic        oTX_EN,
   output logic        oTX_REQ,
   output logic [7:0]  oTX_DATA,
   input  logic        iTX_BUSY,
   input  logic [3:0]  iTX_BUFF_CNT,
   input  logic        iTX_TRANSMIT,
   output logic        oRX_EN,
   output logic        oRX_REQ,
   input  logic        iRX_EMPTY,
   input  logic [7:0]  iRX_DATA,
   input  logic [3:0]  iRX_BUFF_CNT,
   output logic        oIRQ_VALID
);
   typedef enum logic [1:0] {IDLE, TX_WAIT, RESP} state_t;
   state_t      state_q;
   logic [7:0]  ctrl_q, tx_data_q;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, busy_q, tx_en_q, irq_q;
   logic [2:0]  pend_q, pend_d, pend_set, pend_clr;
   logic [3:0]  tx_cnt_q, rx_th;
   logic        acc, wr, rd, pop, top_set;
   logic        unused_in;

   assign acc      = iREQ_VALID && state_q == IDLE && !iRESET_SYNC;
   assign wr       = acc && iREQ_RW;
   assign rd       = acc && !iREQ_RW;
   assign pop      = rd && iREQ_ADDR == 2'd2 && !iRX_EMPTY && ctrl_q[1];
   assign rx_th    = (ctrl_q[7:4] == 4'd0) ? 4'd1 : ctrl_q[7:4];
   assign pend_set = {top_set,
                      ctrl_q[3] && iRX_BUFF_CNT >= rx_th,
                      ctrl_q[2] && tx_cnt_q != 4'd0 && iTX_BUFF_CNT == 4'd0};
   assign pend_clr = (wr && iREQ_ADDR == 2'd3) ? iREQ_DATA[18:16] : 3'd0;
   assign pend_d   = (pend_q & ~pend_clr) | pend_set;
   assign rdata_d  = (iREQ_ADDR == 2'd0) ? {24'h0, ctrl_q} :
                     (iREQ_ADDR == 2'd1) ? {28'h0, iTX_BUFF_CNT} :
                     (iREQ_ADDR == 2'd2) ? (pop ? {1'b1, 23'h0, iRX_DATA} : 32'h0) :
                     {13'h0, pend_q, 6'h0, iRX_EMPTY, iTX_BUSY, iRX_BUFF_CNT, iTX_BUFF_CNT};
   assign unused_in = ^{iTX_TRANSMIT, iREQ_DATA[31:19], iREQ_DATA[15:8]};

   assign oREQ_BUSY  = busy_q;
   assign oREQ_VALID = rvalid_q;
   assign oREQ_DATA  = rdata_q;
   assign oTX_EN     = tx_en_q;
   assign oTX_REQ    = tx_en_q;
   assign oTX_DATA   = tx_data_q;
   assign oRX_EN     = pop;
   assign oRX_REQ    = pop;
   assign oIRQ_VALID = irq_q;

   // Bus FSM with registered outputs, control register and interrupt pending bits
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q   <= IDLE;
         ctrl_q    <= 8'h0;
         tx_data_q <= 8'h0;
         rdata_q   <= 32'h0;
         rvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
         tx_en_q   <= 1'b0;
         irq_q     <= 1'b0;
         pend_q    <= 3'h0;
         tx_cnt_q  <= 4'h0;
      end else if (iRESET_SYNC) begin
         state_q   <= IDLE;
         ctrl_q    <= 8'h0;
         tx_data_q <= 8'h0;
         rdata_q   <= 32'h0;
         rvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
         tx_en_q   <= 1'b0;
         irq_q     <= 1'b0;
         pend_q    <= 3'h0;
         tx_cnt_q  <= 4'h0;
      end else begin
         tx_en_q  <= 1'b0;
         rvalid_q <= 1'b0;
         tx_cnt_q <= iTX_BUFF_CNT;
         pend_q   <= pend_d;
         irq_q    <= |pend_d;
         case (state_q)
            IDLE: begin
               if (wr && iREQ_ADDR == 2'd0) ctrl_q <= iREQ_DATA[7:0];
               if (wr && iREQ_ADDR == 2'd1 && ctrl_q[0]) begin
                  tx_data_q <= iREQ_DATA[7:0];
                  tx_en_q   <= !iTX_BUSY;
                  state_q   <= iTX_BUSY ? TX_WAIT : IDLE;
                  busy_q    <= iTX_BUSY;
               end
               if (rd) begin
                  rdata_q  <= rdata_d;
                  rvalid_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= RESP;
               end
            end
            TX_WAIT: if (!iTX_BUSY) begin
               tx_en_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            RESP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SCI_RX_TIMEOUT_EN
   logic [15:0] to_cnt_q;
   logic [3:0]  rx_cnt_q;
   logic        to_evt, to_run;

   assign to_evt  = rx_cnt_q != iRX_BUFF_CNT || pop;
   assign to_run  = !iRX_EMPTY && ctrl_q[3] && to_cnt_q != P_TIMEOUT - 16'd1;
   assign top_set = !to_evt && to_run && to_cnt_q == P_TIMEOUT - 16'd2;

   // RX idle counter: restarts on level change or pop, saturates at the timeout
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         to_cnt_q <= 16'h0;
         rx_cnt_q <= 4'h0;
      end else if (iRESET_SYNC) begin
         to_cnt_q <= 16'h0;
         rx_cnt_q <= 4'h0;
      end else begin
         rx_cnt_q <= iRX_BUFF_CNT;
         to_cnt_q <= to_evt ? 16'h0 : to_run ? to_cnt_q + 16'd1 : to_cnt_q;
      end
   end
`else
   logic unused_timeout;
   assign top_set        = 1'b0;
   assign unused_timeout = ^P_TIMEOUT;
`endif
endmodule

// File: tb/tb_sci_bus_ctrl.sv
// tb_sci_bus_ctrl: vector table, directed corner sequences and randomized reads/writes against a register-level model
module tb_sci_bus_ctrl;
   logic        iCLOCK, inRESET, iRESET_SYNC;
   logic        iREQ_VALID, iREQ_RW;
   logic [1:0]  iREQ_ADDR;
   logic [31:0] iREQ_DATA;
   logic        oREQ_BUSY, oREQ_VALID;
   logic [31:0] oREQ_DATA;
   logic        oTX_EN, oTX_REQ;
   logic [7:0]  oTX_DATA;
   logic        iTX_BUSY, iTX_TRANSMIT;
   logic [3:0]  iTX_BUFF_CNT, iRX_BUFF_CNT;
   logic        oRX_EN, oRX_REQ, iRX_EMPTY;
   logic [7:0]  iRX_DATA;
   logic        oIRQ_VALID;

   int checks = 0;
   int errors = 0;

   sci_bus_ctrl #(.P_TIMEOUT(16'd10)) dut (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
      .iREQ_VALID(iREQ_VALID), .oREQ_BUSY(oREQ_BUSY), .iREQ_RW(iREQ_RW),
      .iREQ_ADDR(iREQ_ADDR), .iREQ_DATA(iREQ_DATA),
      .oREQ_VALID(oREQ_VALID), .oREQ_DATA(oREQ_DATA),
      .oTX_EN(oTX_EN), .oTX_REQ(oTX_REQ), .oTX_DATA(oTX_DATA),
      .iTX_BUSY(iTX_BUSY), .iTX_BUFF_CNT(iTX_BUFF_CNT), .iTX_TRANSMIT(iTX_TRANSMIT),
      .oRX_EN(oRX_EN), .oRX_REQ(oRX_REQ), .iRX_EMPTY(iRX_EMPTY),
      .iRX_DATA(iRX_DATA), .iRX_BUFF_CNT(iRX_BUFF_CNT), .oIRQ_VALID(oIRQ_VALID)
   );

   initial begin
      iCLOCK = 1'b0;
      forever #5 iCLOCK = ~iCLOCK;
   end

   typedef struct {
      logic [31:0] ctrl;
      logic [1:0]  addr;
      logic        rx_empty;
      logic [7:0]  rx_data;
      logic [3:0]  rx_cnt;
      logic [3:0]  tx_cnt;
      logic        tx_busy;
      logic [31:0] exp;
      logic        exp_pop;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge iCLOCK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      iREQ_VALID = 1'b1;
      iREQ_RW    = 1'b1;
      iREQ_ADDR  = a;
      iREQ_DATA  = d;
      tick();
      iREQ_VALID = 1'b0;
      iREQ_RW    = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic [1:0] p);
      iREQ_VALID = 1'b1;
      iREQ_RW    = 1'b0;
      iREQ_ADDR  = a;
      #1;
      p = {oRX_EN, oRX_REQ};
      tick();
      iREQ_VALID = 1'b0;
      chk("rd_valid", oREQ_VALID, 1);
      d = oREQ_DATA;
      tick();
      chk("rd_valid_one_cycle", oREQ_VALID, 0);
   endtask

   initial begin
      logic [31:0] rd, exp, v;
      logic [1:0]  pp, a;
      logic [7:0]  m_ctrl;
      int          busy_n, push_n, n;
      logic [7:0]  pushed;

      vecs[0] = '{32'h2, 2'd2, 1'b0, 8'hA3, 4'd1, 4'd0, 1'b0, 32'h800000A3, 1'b1};
      vecs[1] = '{32'h2, 2'd2, 1'b1, 8'hA3, 4'd0, 4'd0, 1'b0, 32'h0, 1'b0};
      vecs[2] = '{32'h0, 2'd2, 1'b0, 8'h5A, 4'd1, 4'd0, 1'b0, 32'h0, 1'b0};
      vecs[3] = '{32'hFFFFFFF3, 2'd0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b0, 32'hF3, 1'b0};
      vecs[4] = '{32'h0, 2'd1, 1'b1, 8'h00, 4'd0, 4'd7, 1'b0, 32'h7, 1'b0};
      vecs[5] = '{32'h0, 2'd3, 1'b0, 8'h00, 4'd9, 4'd5, 1'b1, 32'h195, 1'b0};
      vecs[6] = '{32'h0, 2'd3, 1'b1, 8'h00, 4'd0, 4'd15, 1'b1, 32'h30F, 1'b0};
      vecs[7] = '{32'h3, 2'd2, 1'b0, 8'hFF, 4'd3, 4'd0, 1'b0, 32'h800000FF, 1'b1};

      inRESET = 1'b0; iRESET_SYNC = 1'b0; iREQ_VALID = 1'b0; iREQ_RW = 1'b0;
      iREQ_ADDR = 2'd0; iREQ_DATA = 32'h0; iTX_BUSY = 1'b0; iTX_TRANSMIT = 1'b0;
      iTX_BUFF_CNT = 4'd0; iRX_BUFF_CNT = 4'd0; iRX_EMPTY = 1'b1; iRX_DATA = 8'h0;
      repeat (2) tick();
      chk("rst_busy", oREQ_BUSY, 0);
      chk("rst_valid", oREQ_VALID, 0);
      chk("rst_data", oREQ_DATA, 0);
      chk("rst_tx", {oTX_EN, oTX_REQ, oTX_DATA}, 0);
      chk("rst_rx", {oRX_EN, oRX_REQ}, 0);
      chk("rst_irq", oIRQ_VALID, 0);
      inRESET = 1'b1;
      tick();
      bus_read(2'd0, rd, pp);
      chk("rst_ctrl_read", rd, 0);
      chk("rst_irq_after", oIRQ_VALID, 0);

      for (int i = 0; i < 8; i++) begin
         bus_write(2'd0, vecs[i].ctrl);
         iRX_EMPTY    = vecs[i].rx_empty;
         iRX_DATA     = vecs[i].rx_data;
         iRX_BUFF_CNT = vecs[i].rx_cnt;
         iTX_BUFF_CNT = vecs[i].tx_cnt;
         iTX_BUSY     = vecs[i].tx_busy;
         bus_read(vecs[i].addr, rd, pp);
         chk($sformatf("vec%0d_data", i), rd, vecs[i].exp);
         chk($sformatf("vec%0d_pop", i), pp, {vecs[i].exp_pop, vecs[i].exp_pop});
      end

      iTX_BUSY = 1'b0; iTX_BUFF_CNT = 4'd0; iRX_BUFF_CNT = 4'd0; iRX_EMPTY = 1'b1;
      bus_write(2'd0, 32'h1);
      bus_write(2'd1, 32'h55);
      chk("tx_push", {oTX_EN, oTX_REQ}, 2'b11);
      chk("tx_data", oTX_DATA, 8'h55);
      chk("tx_no_busy", oREQ_BUSY, 0);
      tick();
      chk("tx_one_pulse", oTX_EN, 0);

      iTX_BUSY = 1'b1;
      bus_write(2'd1, 32'hC3);
      busy_n = 0; push_n = 0; pushed = 8'h0;
      for (int i = 1; i <= 12; i++) begin
         iTX_BUSY = (i < 5);
         busy_n += int'(oREQ_BUSY);
         if (oTX_EN) begin
            push_n++;
            pushed = oTX_DATA;
         end
         tick();
      end
      chk("stall_busy_cycles", busy_n, 5);
      chk("stall_push_count", push_n, 1);
      chk("stall_push_data", pushed, 8'hC3);

      bus_write(2'd0, 32'h0);
      bus_write(2'd1, 32'h77);
      push_n = int'(oTX_EN);
      tick();
      push_n += int'(oTX_EN);
      chk("ten0_dropped", push_n, 0);

      m_ctrl = 8'h0;
      for (int i = 0; i < 300; i++) begin
         case ($urandom % 3)
            0: begin
               v = $urandom & ~32'hC;
               bus_write(2'd0, v);
               m_ctrl = v[7:0];
            end
            1: begin
               iRX_EMPTY    = 1'($urandom);
               iRX_DATA     = 8'($urandom);
               iRX_BUFF_CNT = 4'($urandom);
               iTX_BUFF_CNT = 4'($urandom);
               iTX_BUSY     = 1'($urandom);
               a            = 2'($urandom);
               case (a)
                  2'd0: exp = {24'h0, m_ctrl};
                  2'd1: exp = 32'(iTX_BUFF_CNT);
                  2'd2: exp = (m_ctrl[1] && !iRX_EMPTY) ? 32'h80000000 + 32'(iRX_DATA) : 32'h0;
                  default: exp = 32'(iTX_BUFF_CNT) + 32'(iRX_BUFF_CNT) * 16 +
                                 32'(iTX_BUSY) * 256 + 32'(iRX_EMPTY) * 512;
               endcase
               bus_read(a, rd, pp);
               chk($sformatf("rnd%0d_a%0d_data", i, a), rd, exp);
               chk($sformatf("rnd%0d_pop", i), pp,
                   (a == 2'd2 && m_ctrl[1] && !iRX_EMPTY) ? 2'b11 : 2'b00);
               chk($sformatf("rnd%0d_irq", i), oIRQ_VALID, 0);
            end
            default: begin
               iTX_BUSY = 1'b0;
               v = $urandom;
               bus_write(2'd1, v);
               chk($sformatf("rnd%0d_txpush", i), oTX_EN, m_ctrl[0]);
               if (m_ctrl[0]) chk($sformatf("rnd%0d_txdata", i), oTX_DATA, v[7:0]);
            end
         endcase
      end

      iTX_BUSY = 1'b0; iTX_BUFF_CNT = 4'd0; iRX_BUFF_CNT = 4'd0; iRX_EMPTY = 1'b1;
      bus_write(2'd0, 32'h0);
      bus_write(2'd3, 32'h70000);
      bus_write(2'd0, 32'h28);
      iRX_EMPTY = 1'b0;
      iRX_BUFF_CNT = 4'd1;
      tick();
      tick();
      chk("rxp_below_th", oIRQ_VALID, 0);
      iRX_BUFF_CNT = 4'd2;
      chk("rxp_not_same_cycle", oIRQ_VALID, 0);
      tick();
      chk("rxp_irq", oIRQ_VALID, 1);
      bus_write(2'd3, 32'h20000);
      chk("rxp_set_wins_irq", oIRQ_VALID, 1);
      bus_read(2'd3, rd, pp);
      chk("rxp_set_wins_status", rd, 32'h20020);
      iRX_BUFF_CNT = 4'd1;
      tick();
      chk("rxp_sticky", oIRQ_VALID, 1);
      bus_write(2'd3, 32'h20000);
      chk("rxp_cleared", oIRQ_VALID, 0);
      bus_write(2'd0, 32'h08);
      tick();
      chk("rxth0_is_1", oIRQ_VALID, 1);

      iRX_BUFF_CNT = 4'd0; iRX_EMPTY = 1'b1;
      bus_write(2'd0, 32'h4);
      bus_write(2'd3, 32'h70000);
      chk("txp_pre_clear", oIRQ_VALID, 0);
      iTX_BUFF_CNT = 4'd1;
      tick();
      chk("txp_nonzero", oIRQ_VALID, 0);
      iTX_BUFF_CNT = 4'd0;
      tick();
      chk("txp_irq", oIRQ_VALID, 1);
      repeat (3) tick();
      chk("txp_level", oIRQ_VALID, 1);
      bus_write(2'd3, 32'h10000);
      chk("txp_cleared", oIRQ_VALID, 0);

`ifdef SCI_RX_TIMEOUT_EN
      bus_write(2'd0, 32'h4A);
      bus_write(2'd3, 32'h70000);
      iRX_EMPTY = 1'b0;
      iRX_BUFF_CNT = 4'd1;
      n = 0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (oIRQ_VALID) begin
            n = k;
            break;
         end
      end
      chk("top_delay", n, 10);
      bus_read(2'd3, rd, pp);
      chk("top_bit", rd[18], 1);
      bus_write(2'd3, 32'h40000);
      chk("top_cleared", oIRQ_VALID, 0);
      iRX_BUFF_CNT = 4'd2;
      repeat (5) tick();
      bus_read(2'd2, rd, pp);
      chk("top_pop", pp, 2'b11);
      chk("top_restart_quiet", oIRQ_VALID, 0);
      n = 0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (oIRQ_VALID) begin
            n = k;
            break;
         end
      end
      chk("top_after_pop", n, 8);
      iRX_BUFF_CNT = 4'd0; iRX_EMPTY = 1'b1;
      bus_write(2'd3, 32'h70000);
`endif

      bus_write(2'd0, 32'h09);
      iRX_EMPTY = 1'b0;
      iRX_BUFF_CNT = 4'd1;
      tick();
      chk("srst_irq_before", oIRQ_VALID, 1);
      iTX_BUSY = 1'b1;
      bus_write(2'd1, 32'h99);
      chk("srst_stalled", oREQ_BUSY, 1);
      iRESET_SYNC = 1'b1;
      #1;
      chk("srst_no_pop", {oRX_EN, oRX_REQ}, 0);
      tick();
      iRESET_SYNC = 1'b0;
      chk("srst_busy", oREQ_BUSY, 0);
      chk("srst_tx", {oTX_EN, oTX_REQ, oTX_DATA}, 0);
      chk("srst_irq", oIRQ_VALID, 0);
      chk("srst_resp", {oREQ_VALID, oREQ_DATA}, 0);
      iTX_BUSY = 1'b0;
      push_n = 0;
      for (int i = 0; i < 4; i++) begin
         push_n += int'(oTX_EN);
         tick();
      end
      chk("srst_byte_discarded", push_n, 0);
      bus_read(2'd0, rd, pp);
      chk("srst_ctrl", rd, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
